// File: rtl/bank_read_collector_if.sv
// Request, bank-side and response signals of the bank read collector.
// The slave modport is the collector itself; master is whoever drives it.
interface bank_read_collector_if #(
  parameter int DATA_WIDTH = 8
);
  localparam int PARITY_BITS  = $clog2(DATA_WIDTH) + 1;
  localparam int ENCODED_WORD = DATA_WIDTH + PARITY_BITS;

  logic                    i_rd_req;
  logic [1:0]              i_sel;
  logic                    o_req_ready;
  logic [3:0]              o_bank_rd_en;
  logic [3:0]              i_bank_valid;
  logic [ENCODED_WORD+1:1] i_bank_data0;
  logic [ENCODED_WORD+1:1] i_bank_data1;
  logic [ENCODED_WORD+1:1] i_bank_data2;
  logic [ENCODED_WORD+1:1] i_bank_data3;
  logic [ENCODED_WORD+1:1] o_data;
  logic                    o_valid;
  logic                    o_err;
  logic                    i_ready;
  logic                    o_busy;

  modport master (
    output i_rd_req, i_sel, i_bank_valid, i_ready,
    output i_bank_data0, i_bank_data1, i_bank_data2, i_bank_data3,
    input  o_req_ready, o_bank_rd_en, o_data, o_valid, o_err, o_busy
  );

  modport slave (
    input  i_rd_req, i_sel, i_bank_valid, i_ready,
    input  i_bank_data0, i_bank_data1, i_bank_data2, i_bank_data3,
    output o_req_ready, o_bank_rd_en, o_data, o_valid, o_err, o_busy
  );
endinterface

// File: rtl/bank_read_collector.sv
// Issues a one-cycle read enable to one of four banks, waits for its valid
// (or times out) and holds the captured encoded word under valid/ready.
module bank_read_collector #(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  bank_read_collector_if.slave   bus
);
  localparam int PARITY_BITS  = $clog2(DATA_WIDTH) + 1;
  localparam int ENCODED_WORD = DATA_WIDTH + PARITY_BITS;
  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t                  state_reg, state_next;
  logic [1:0]              sel_reg, sel_next;
  logic [7:0]              count_reg, count_next;
  logic [3:0]              rd_en_reg, rd_en_next;
  logic [ENCODED_WORD+1:1] data_reg, data_next;
  logic                    valid_reg, valid_next;
  logic                    err_reg, err_next;
  logic [ENCODED_WORD+1:1] bank_word;

  always_comb begin
    bank_word = bus.i_bank_data0;
    case (sel_reg)
      2'd1:    bank_word = bus.i_bank_data1;
      2'd2:    bank_word = bus.i_bank_data2;
      2'd3:    bank_word = bus.i_bank_data3;
      default: bank_word = bus.i_bank_data0;
    endcase
  end

  // The enable is registered at the accept edge so it is visible exactly during ISSUE.
  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    count_next = count_reg;
    rd_en_next = 4'b0000;
    data_next  = data_reg;
    valid_next = valid_reg;
    err_next   = err_reg;
    case (state_reg)
      IDLE: begin
        if (bus.i_rd_req) begin
          sel_next   = bus.i_sel;
          rd_en_next = 4'b0001 << bus.i_sel;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        count_next = 8'd0;
        state_next = WAIT;
      end
      WAIT: begin
        if (bus.i_bank_valid[sel_reg]) begin
          data_next  = bank_word;
          valid_next = 1'b1;
          err_next   = 1'b0;
          state_next = HOLD;
        end else if (count_reg == LAST_COUNT) begin
          data_next  = '0;
          valid_next = 1'b1;
          err_next   = 1'b1;
          state_next = HOLD;
        end else begin
          count_next = count_reg + 8'd1;
        end
      end
      HOLD: begin
        if (valid_reg && bus.i_ready) begin
          valid_next = 1'b0;
          err_next   = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sel_reg   <= 2'd0;
      count_reg <= 8'd0;
      rd_en_reg <= 4'b0000;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      sel_reg   <= sel_next;
      count_reg <= count_next;
      rd_en_reg <= rd_en_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      err_reg   <= err_next;
    end
  end

  assign bus.o_req_ready  = (state_reg == IDLE);
  assign bus.o_busy       = (state_reg != IDLE);
  assign bus.o_bank_rd_en = rd_en_reg;
  assign bus.o_data       = data_reg;
  assign bus.o_valid      = valid_reg;
  assign bus.o_err        = err_reg;
endmodule

// File: tb/tb_bank_read_collector.sv
// Directed bench for bank_read_collector: a transaction-level model, timed
// relative to each accept edge, is compared against the DUT every cycle.
module tb_bank_read_collector;
  localparam int T = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bank_read_collector_if #(.DATA_WIDTH(8)) bus ();

  bank_read_collector #(.DATA_WIDTH(8), .TIMEOUT_CYCLES(T)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;
  logic chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one outstanding transaction, timed by edge count since accept.
  int         m_cyc, m_acc;
  logic       m_busy, m_resp, m_err;
  logic [1:0] m_sel;
  logic [12:0] m_data;

  function automatic logic [12:0] bank_of(input logic [1:0] s);
    case (s)
      2'd0:    return bus.i_bank_data0;
      2'd1:    return bus.i_bank_data1;
      2'd2:    return bus.i_bank_data2;
      default: return bus.i_bank_data3;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cyc  <= 0;
      m_acc  <= -100;
      m_busy <= 1'b0;
      m_resp <= 1'b0;
      m_err  <= 1'b0;
      m_sel  <= 2'd0;
      m_data <= '0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (m_busy && m_resp) begin
        if (bus.i_ready) begin
          m_busy <= 1'b0;
          m_resp <= 1'b0;
          m_err  <= 1'b0;
        end
      end else if (m_busy) begin
        // WAIT samples happen on edges 2 .. T+1 after the accept edge
        if ((m_cyc + 1 - m_acc) >= 2 && bus.i_bank_valid[m_sel]) begin
          m_data <= bank_of(m_sel);
          m_err  <= 1'b0;
          m_resp <= 1'b1;
        end else if ((m_cyc + 1 - m_acc) == T + 1) begin
          m_data <= '0;
          m_err  <= 1'b1;
          m_resp <= 1'b1;
        end
      end else if (bus.i_rd_req) begin
        m_busy <= 1'b1;
        m_acc  <= m_cyc + 1;
        m_sel  <= bus.i_sel;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("m_rd_en", 32'(bus.o_bank_rd_en), 32'((m_busy && m_cyc == m_acc) ? (4'b0001 << m_sel) : 4'b0000));
      check("m_valid", 32'(bus.o_valid), 32'(m_busy && m_resp));
      check("m_err", 32'(bus.o_err), 32'(m_err));
      check("m_data", 32'(bus.o_data), 32'(m_data));
      check("m_req_ready", 32'(bus.o_req_ready), 32'(!m_busy));
      check("m_busy", 32'(bus.o_busy), 32'(m_busy));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  // Places a one-cycle request; returns at the negedge inside cycle 1 (ISSUE).
  task automatic start_req(input logic [1:0] s);
    bus.i_rd_req = 1'b1;
    bus.i_sel    = s;
    step();
    bus.i_rd_req = 1'b0;
    bus.i_sel    = ~s;
  endtask

  logic [3:0] rd_en_seen;

  initial begin
    bus.i_rd_req = 1'b0;
    bus.i_sel = 2'd0;
    bus.i_bank_valid = 4'b0000;
    bus.i_bank_data0 = '0;
    bus.i_bank_data1 = '0;
    bus.i_bank_data2 = '0;
    bus.i_bank_data3 = '0;
    bus.i_ready = 1'b0;

    // Asynchronous reset asserted mid-cycle
    step();
    #2 rst = 1'b1;
    #1;
    check("rst_valid", 32'(bus.o_valid), 32'd0);
    check("rst_err", 32'(bus.o_err), 32'd0);
    check("rst_data", 32'(bus.o_data), 32'd0);
    check("rst_rd_en", 32'(bus.o_bank_rd_en), 32'd0);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    check("rst_req_ready", 32'(bus.o_req_ready), 32'd1);
    step();
    rst = 1'b0;
    chk_on = 1'b1;
    rd_en_seen = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      step();
      rd_en_seen = rd_en_seen | bus.o_bank_rd_en;
    end
    check("idle_no_rd_en", 32'(rd_en_seen), 32'd0);

    // Basic read from bank 2
    start_req(2'd2);
    check("basic_rd_en", 32'(bus.o_bank_rd_en), 32'h4);
    step();
    check("basic_rd_en_once", 32'(bus.o_bank_rd_en), 32'h0);
    bus.i_bank_data2 = 13'h0A5B;
    bus.i_bank_valid = 4'b0100;
    step();
    check("basic_valid", 32'(bus.o_valid), 32'd1);
    check("basic_data", 32'(bus.o_data), 32'h0A5B);
    check("basic_err", 32'(bus.o_err), 32'd0);
    bus.i_bank_valid = 4'b0000;
    bus.i_ready = 1'b1;
    step();
    check("basic_done_valid", 32'(bus.o_valid), 32'd0);
    check("basic_done_ready", 32'(bus.o_req_ready), 32'd1);
    bus.i_ready = 1'b0;
    step();

    // Backpressure, then a request held through the handshake cycle
    start_req(2'd2);
    step();
    bus.i_bank_valid = 4'b0100;
    step();
    for (int i = 0; i < 5; i++) begin
      check("bp_data", 32'(bus.o_data), 32'h0A5B);
      check("bp_valid", 32'(bus.o_valid), 32'd1);
      bus.i_bank_data2 = 13'(13'h0100 + i);
      step();
    end
    bus.i_bank_valid = 4'b0000;
    bus.i_ready = 1'b1;
    bus.i_rd_req = 1'b1;
    bus.i_sel = 2'd1;
    step();
    check("bp_release_valid", 32'(bus.o_valid), 32'd0);
    check("no_back_to_back", 32'(bus.o_busy), 32'd0);
    bus.i_ready = 1'b0;
    step();
    check("late_accept_rd_en", 32'(bus.o_bank_rd_en), 32'h2);
    bus.i_rd_req = 1'b0;
    step();
    bus.i_bank_data1 = 13'h0456;
    bus.i_bank_valid = 4'b0010;
    step();
    check("late_accept_data", 32'(bus.o_data), 32'h0456);
    bus.i_bank_valid = 4'b0000;
    bus.i_ready = 1'b1;
    step();
    bus.i_ready = 1'b0;

    // Non-selected bank valid is ignored
    start_req(2'd1);
    step();
    bus.i_bank_data3 = 13'h1FFF;
    bus.i_bank_valid = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      step();
      check("wb_no_valid", 32'(bus.o_valid), 32'd0);
    end
    bus.i_bank_data1 = 13'h0123;
    bus.i_bank_valid = 4'b1010;
    step();
    check("wb_data", 32'(bus.o_data), 32'h0123);
    check("wb_valid", 32'(bus.o_valid), 32'd1);
    bus.i_bank_valid = 4'b0000;
    bus.i_ready = 1'b1;
    step();
    bus.i_ready = 1'b0;

    // Timeout with no valid: response in cycle T+2
    start_req(2'd0);
    for (int c = 2; c <= T + 1; c++) step();
    check("to_not_yet", 32'(bus.o_valid), 32'd0);
    step();
    check("to_valid", 32'(bus.o_valid), 32'd1);
    check("to_err", 32'(bus.o_err), 32'd1);
    check("to_data", 32'(bus.o_data), 32'd0);
    bus.i_ready = 1'b1;
    step();
    bus.i_ready = 1'b0;

    // Valid on the last WAIT cycle wins over the timeout
    start_req(2'd0);
    for (int c = 2; c <= T + 1; c++) begin
      step();
      if (c == T + 1) begin
        bus.i_bank_data0 = 13'h0777;
        bus.i_bank_valid = 4'b0001;
      end
    end
    step();
    check("late_valid_err", 32'(bus.o_err), 32'd0);
    check("late_valid_data", 32'(bus.o_data), 32'h0777);
    bus.i_bank_valid = 4'b0000;
    bus.i_ready = 1'b1;
    step();
    bus.i_ready = 1'b0;

    // Valid only during the ISSUE cycle is ignored, so this times out
    bus.i_rd_req = 1'b1;
    bus.i_sel = 2'd2;
    step();
    bus.i_rd_req = 1'b0;
    bus.i_bank_valid = 4'b0100;
    step();
    bus.i_bank_valid = 4'b0000;
    for (int c = 3; c <= T + 2; c++) step();
    check("issue_valid_ignored", 32'(bus.o_err), 32'd1);
    bus.i_ready = 1'b1;
    step();
    bus.i_ready = 1'b0;

    // Reset during WAIT discards the request
    start_req(2'd1);
    step();
    #2 rst = 1'b1;
    #1 check("rst_wait_busy", 32'(bus.o_busy), 32'd0);
    step();
    rst = 1'b0;
    bus.i_bank_data1 = 13'h0999;
    bus.i_bank_valid = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_wait_no_valid", 32'(bus.o_valid), 32'd0);
    end
    bus.i_bank_valid = 4'b0000;
    start_req(2'd3);
    check("post_rst_rd_en", 32'(bus.o_bank_rd_en), 32'h8);
    step();
    bus.i_bank_data3 = 13'h0ABC;
    bus.i_bank_valid = 4'b1000;
    step();
    check("post_rst_data", 32'(bus.o_data), 32'h0ABC);
    bus.i_bank_valid = 4'b0000;
    bus.i_ready = 1'b1;
    step();
    bus.i_ready = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
